// File: rtl/nibble_serial_adder.sv
// Serial add/subtract of two W-bit operands, one nibble per clock, LSB nibble first.
// A single 4-bit ripple adder is reused every cycle; the nibble carry lives in c_r.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       overflow
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  // The nibble carry-out, not a signed overflow flag.
  assign overflow = c[4];

endmodule

module nibble_serial_adder #(
  parameter int NUM_NIBBLES = 4,
  localparam int W  = 4 * NUM_NIBBLES,
  localparam int CW = $clog2(NUM_NIBBLES)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  // Handshake: start is sampled only in IDLE; busy marks the ADD cycles; done is a
  // one-cycle pulse after which result/carry_out/overflow stay valid until the next start.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_NIBBLES - 1);

  logic [1:0]    state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic          sub_r;
  logic          c_r;
  logic [CW-1:0] cnt;

  logic [3:0]    b_eff;
  logic [3:0]    nib_sum;
  logic          nib_cout;
  logic          last_nib;

  assign b_eff    = b_sr[3:0] ^ {4{sub_r}};
  assign last_nib = (cnt == LAST_CNT);

  adder_4bit u_adder (
    .a        (a_sr[3:0]),
    .b        (b_eff),
    .carry_in (c_r),
    .sum      (nib_sum),
    .overflow (nib_cout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= start ? ADD : IDLE;
        ADD:     state <= last_nib ? DONE : ADD;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      sub_r <= 1'b0;
      c_r   <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      a_sr  <= op_a;
      b_sr  <= op_b;
      sub_r <= sub;
      // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
      c_r   <= sub;
      cnt   <= '0;
    end else if (state == ADD) begin
      a_sr  <= {4'b0000, a_sr[W-1:4]};
      b_sr  <= {4'b0000, b_sr[W-1:4]};
      c_r   <= nib_cout;
      cnt   <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == ADD) begin
      result <= {nib_sum, result[W-1:4]};
      if (last_nib) begin
        carry_out <= nib_cout;
        overflow  <= (a_sr[3] == b_eff[3]) && (nib_sum[3] != a_sr[3]);
      end
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: driver pushes expected results into a
// queue, a monitor pops and compares on every done pulse.

module tb_nibble_serial_adder;

  localparam int NN = 4;
  localparam int W  = 4 * NN;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  logic [W+1:0] exp_q[$];
  int           checks;
  int           errors;
  int           done_cnt;

  nibble_serial_adder #(.NUM_NIBBLES(NN)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (n_rst && done) begin
      logic [W+1:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result 0x%0h with no expected entry", result);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(e[W]));
        check("overflow", 32'(overflow), 32'(e[W+1]));
      end
    end
  end

  // driver: issue one operation and follow it through to IDLE
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] r, input logic c, input logic ov);
    int busy_n;
    int guard;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    exp_q.push_back({ov, c, r});
    @(negedge clk);
    start = 1'b0;
    op_a = ~a; op_b = W'($urandom); sub = ~s;
    busy_n = 0;
    guard  = 0;
    while (busy && guard < 50) begin
      busy_n++;
      guard++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_n), 32'(NN));
    check("done_after_busy", 32'(done), 32'd1);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    @(negedge clk);
    check("result_hold", 32'(result), 32'(r));
  endtask

  initial begin
    int d0;
    checks = 0; errors = 0; done_cnt = 0;
    start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    n_rst = 1'b1;

    // basic add, wrap, signed overflow, subtract with/without borrow
    do_op(16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulses during ADD and DONE are ignored; first IDLE start is accepted
    d0 = done_cnt;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FCC; sub = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 16'h2200});
    @(negedge clk);
    start = 1'b0; op_a = 16'hAAAA; op_b = 16'h5555;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    check("ign_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    check("ign_idle_busy", 32'(busy), 32'd0);
    check("ign_idle_done", 32'(done), 32'd0);
    op_a = 16'h0003; op_b = 16'h0004; sub = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 16'h0007});
    @(negedge clk);
    start = 1'b0;
    check("ign_accept_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    @(negedge clk);
    check("ign_done_count", 32'(done_cnt - d0), 32'd2);

    // reset during the second ADD cycle aborts without a done
    d0 = done_cnt;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FCC; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
